pulse_height_analyzer: RTL and testbench

- Consumes the signed 16-bit shaped stream produced by the shaping filter, one sample per clk.
- Detects pulses by threshold crossing and tracks each pulse's maximum.
- Emits one event per accepted pulse: peak height plus timestamp, over a valid/ready handshake.
- Sits between the shaper and the histogram/readout logic; rejects short glitches and pile-up.

---
 rtl/pulse_height_analyzer.sv | 164 ++++++++++++++++
 tb/tb_pulse_height_analyzer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_height_analyzer.sv
// Pulse height analyzer: threshold trigger, peak/width/timestamp capture, one-deep event output.
// Optional PHA_BASELINE_RESTORE_EN subtracts a 16-sample idle baseline before triggering.
module pulse_height_analyzer #(
   parameter int DATA_W    = 16,
   parameter int THRESHOLD = 200,
   parameter int MIN_WIDTH = 4,
   parameter int MAX_WIDTH = 1536,
   parameter int HOLDOFF   = 1024,
   parameter int TS_W      = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] shp,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic signed [DATA_W-1:0] ev_peak,
   output logic [TS_W-1:0]          ev_time,
   output logic [15:0]              ev_width,
   output logic [7:0]               drop_cnt,
   output logic                     busy
);
   localparam int HW = $clog2(HOLDOFF + 1);
   localparam logic signed [DATA_W-1:0] THR = DATA_W'(THRESHOLD);

   typedef enum logic [1:0] {IDLE, RISE, HOLD} state_t;
   state_t state;

   logic [TS_W-1:0]          ts_cnt, ts_r;
   logic signed [DATA_W-1:0] shp_r;
   logic signed [DATA_W-1:0] smp;
   logic [TS_W-1:0]          smp_ts;
   logic signed [DATA_W-1:0] peak;
   logic [15:0]              width;
   logic [TS_W-1:0]          t0;
   logic [HW-1:0]            hold_cnt;
   logic                     above, emit;

   // Sample and timestamp travel together so t0 is exact for the triggering sample
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt <= '0;
         ts_r   <= '0;
         shp_r  <= '0;
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
         ts_r   <= ts_cnt;
         shp_r  <= shp;
      end
   end

`ifdef PHA_BASELINE_RESTORE_EN
   logic signed [DATA_W-1:0] win [16];
   logic signed [DATA_W+3:0] acc;
   logic signed [DATA_W-1:0] base;
   logic signed [DATA_W:0]   diff;
   logic signed [DATA_W-1:0] diff_sat;
   logic signed [DATA_W-1:0] smp_q;
   logic [TS_W-1:0]          ts_q;

   assign base = DATA_W'(acc >>> 4);

   always_comb begin
      diff = {shp_r[DATA_W-1], shp_r} - {base[DATA_W-1], base};
      if (diff[DATA_W] != diff[DATA_W-1])
         diff_sat = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
         diff_sat = diff[DATA_W-1:0];
   end

   // Baseline window only learns while idle so pulses do not bias it
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         smp_q <= '0;
         ts_q  <= '0;
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else begin
         smp_q <= diff_sat;
         ts_q  <= ts_r;
         if (state == IDLE) begin
            acc <= acc + (DATA_W+4)'(shp_r) - (DATA_W+4)'(win[15]);
            for (int i = 15; i > 0; i--) win[i] <= win[i-1];
            win[0] <= shp_r;
         end
      end
   end

   assign smp    = smp_q;
   assign smp_ts = ts_q;
`else
   assign smp    = shp_r;
   assign smp_ts = ts_r;
`endif

   assign above = smp > THR;
   assign emit  = (state == RISE) && !above && (width >= 16'(MIN_WIDTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         peak     <= '0;
         width    <= '0;
         t0       <= '0;
         hold_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (above) begin
               state <= RISE;
               busy  <= 1'b1;
               peak  <= smp;
               width <= 16'd1;
               t0    <= smp_ts;
            end
            RISE: if (above) begin
               width <= width + 16'd1;
               if (smp > peak) peak <= smp;
               if (width == 16'(MAX_WIDTH - 1)) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end
            end else if (width >= 16'(MIN_WIDTH)) begin
               state    <= HOLD;
               hold_cnt <= '0;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            HOLD: if (hold_cnt == HW'(HOLDOFF - 1)) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else begin
               hold_cnt <= hold_cnt + HW'(1);
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // One-deep output: a new event only replaces the old one when it leaves this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         ev_valid <= 1'b0;
         ev_peak  <= '0;
         ev_time  <= '0;
         ev_width <= '0;
         drop_cnt <= '0;
      end else if (emit) begin
         if (!ev_valid || ev_ready) begin
            ev_valid <= 1'b1;
            ev_peak  <= peak;
            ev_time  <= t0;
            ev_width <= width;
         end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end else if (ev_ready) begin
         ev_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pulse_height_analyzer.sv
// Directed bench for pulse_height_analyzer with hand-computed expectations (HOLDOFF shortened).
module tb_pulse_height_analyzer;
   localparam int HOLD_T = 40;
   localparam int MAXW   = 1536;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [15:0] shp = '0;
   logic               ev_ready = 1'b0;
   logic               ev_valid;
   logic signed [15:0] ev_peak;
   logic [31:0]        ev_time;
   logic [15:0]        ev_width;
   logic [7:0]         drop_cnt;
   logic               busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   pulse_height_analyzer #(.HOLDOFF(HOLD_T)) dut (
      .clk(clk), .rst(rst), .shp(shp),
      .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_peak(ev_peak), .ev_time(ev_time), .ev_width(ev_width),
      .drop_cnt(drop_cnt), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one sample, let it be captured, then look #1 after the edge
   task automatic tick(input logic signed [15:0] v);
      shp = v;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick(16'sd0);
      rst = 1'b0;
      cyc = 0;
   endtask

   // Triangle 0, 100, ... amp, ... 100, 0 at 100 per clk
   task automatic pulse(input int amp);
      for (int a = 0; a < amp; a += 100) tick(16'(a));
      for (int a = amp; a > 0; a -= 100) tick(16'(a));
      tick(16'sd0);
   endtask

   task automatic wait_ev(input string tag);
      for (int n = 0; n < 50 && !ev_valid; n++) tick(16'sd0);
      chk(tag, 32'(ev_valid), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      for (int n = 0; n < 3000 && busy; n++) tick(16'sd0);
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic xfer();
      ev_ready = 1'b1;
      tick(16'sd0);
      ev_ready = 1'b0;
   endtask

   initial begin
      int t, n, first_low;
      logic seen_v, seen_b;

      do_reset();
      chk("rst_valid", 32'(ev_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_peak", 32'(ev_peak), 32'd0);
      chk("rst_time", ev_time, 32'd0);

      // Quiet input
      seen_v = 1'b0; seen_b = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         tick(16'sd0);
         if (ev_valid) seen_v = 1'b1;
         if (busy) seen_b = 1'b1;
      end
      chk("quiet_valid", 32'(seen_v), 32'd0);
      chk("quiet_busy", 32'(seen_b), 32'd0);
      chk("quiet_drop", 32'(drop_cnt), 32'd0);

      // Triangle: sample 300 lands on ts 50, first <=200 sample is index 18
      do_reset();
      repeat (47) tick(16'sd0);
      for (int i = 0; i <= 20; i++) begin
         tick(16'(i <= 10 ? 100 * i : 100 * (20 - i)));
         if (i == 18) chk("tri_pre", 32'(ev_valid), 32'd0);
         if (i == 19) chk("tri_rise", 32'(ev_valid), 32'd1);
      end
      chk("tri_peak", 32'(ev_peak), 32'd1000);
      chk("tri_width", 32'(ev_width), 32'd15);
      chk("tri_time", ev_time, 32'd50);
      n = 0;
      while (busy && n < HOLD_T + 20) begin
         tick(16'sd0);
         n++;
      end
      chk("hold_len", 32'(n), 32'(HOLD_T - 1));
      chk("tri_stable", 32'(ev_peak), 32'd1000);
      xfer();
      chk("xfer_low", 32'(ev_valid), 32'd0);

      // Glitch of 3 samples, then valid pulse 5 cycles later
      repeat (3) tick(16'sd500);
      tick(16'sd0);
      tick(16'sd0);
      chk("glitch_busy", 32'(busy), 32'd0);
      chk("glitch_noev", 32'(ev_valid), 32'd0);
      repeat (3) tick(16'sd0);
      t = cyc;
      pulse(1000);
      wait_ev("glitch_next_ev");
      chk("glitch_next_peak", 32'(ev_peak), 32'd1000);
      chk("glitch_next_time", ev_time, 32'(t + 3));

      // Pulse during HOLD is ignored; same pulse after HOLD is captured
      xfer();
      pulse(600);
      wait_idle("hold_idle");
      chk("hold_ignored", 32'(ev_valid), 32'd0);
      t = cyc;
      pulse(600);
      wait_ev("after_hold_ev");
      chk("after_hold_peak", 32'(ev_peak), 32'd600);
      chk("after_hold_width", 32'(ev_width), 32'd7);
      chk("after_hold_time", ev_time, 32'(t + 3));

      // Boundaries: equal to threshold, negative, exactly MIN_WIDTH with a tie
      xfer();
      wait_idle("bnd_idle");
      repeat (10) tick(16'sd200);
      tick(16'sd0);
      tick(16'sd0);
      chk("thr_equal", 32'(busy), 32'd0);
      repeat (10) tick(-16'sd1000);
      chk("negative", 32'(busy), 32'd0);
      t = cyc;
      tick(16'sd300); tick(16'sd500); tick(16'sd500); tick(16'sd300);
      tick(16'sd0);
      tick(16'sd0);
      chk("min_valid", 32'(ev_valid), 32'd1);
      chk("min_width", 32'(ev_width), 32'd4);
      chk("min_peak", 32'(ev_peak), 32'd500);
      chk("min_time", ev_time, 32'(t));

      // Backpressure
      do_reset();
      t = cyc;
      pulse(1000);
      wait_ev("bp_first");
      for (int p = 0; p < 2; p++) begin
         wait_idle("bp_idle");
         pulse(700);
         tick(16'sd0);
         tick(16'sd0);
      end
      chk("bp_drop", 32'(drop_cnt), 32'd2);
      chk("bp_keep_peak", 32'(ev_peak), 32'd1000);
      chk("bp_keep_time", ev_time, 32'(t + 3));
      chk("bp_keep_valid", 32'(ev_valid), 32'd1);
      xfer();
      chk("bp_xfer_low", 32'(ev_valid), 32'd0);
      for (int p = 0; p < 300; p++) begin
         wait_idle("bp_loop_idle");
         pulse(700);
      end
      chk("bp_sat", 32'(drop_cnt), 32'd255);
      chk("bp_loaded_peak", 32'(ev_peak), 32'd700);

      // Pile-up: busy dips for one cycle only after MAX_WIDTH + HOLDOFF
      do_reset();
      ev_ready = 1'b1;
      seen_v = 1'b0;
      first_low = -1;
      for (int k = 0; k < 2000; k++) begin
         tick(16'sd800);
         if (ev_valid) seen_v = 1'b1;
         if (k > 0 && !busy && first_low < 0) first_low = k;
      end
      chk("pile_noev", 32'(seen_v), 32'd0);
      chk("pile_hold_at", 32'(first_low), 32'(MAXW + HOLD_T));

      // Reset mid-pulse
      rst = 1'b1;
      tick(16'sd800);
      rst = 1'b0;
      chk("mid_rst_valid", 32'(ev_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
      chk("mid_rst_peak", 32'(ev_peak), 32'd0);
      chk("mid_rst_width", 32'(ev_width), 32'd0);
      seen_v = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick(16'sd0);
         if (ev_valid) seen_v = 1'b1;
      end
      chk("mid_rst_noev", 32'(seen_v), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
